// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: opcodes, FSM states,
// ALU operation codes and the PCSrc/RegDst select codes also used by the datapath selectors.
package multicycle_control_unit_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_MEMA = 3'b010,
    S_MEM  = 3'b011,
    S_WBL  = 3'b100,
    S_BEQ  = 3'b101,
    S_EXE  = 3'b110,
    S_WB   = 3'b111
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLT  = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic               pc_wre;
    logic               ins_mem_rw;
    logic               ir_wre;
    logic               ext_sel;
    logic               alu_src_a;
    logic               alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_wre;
    logic [1:0]         reg_dst;
    logic               wr_reg_d_src;
    logic               db_data_src;
    logic               m_rd;
    logic               m_wr;
    logic [1:0]         pc_src;
  } ctrl_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
      OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_op_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:        return ALU_SUB;
      OP_OR, OP_ORI: return ALU_OR;
      OP_AND:        return ALU_AND;
      OP_SLL:        return ALU_SLL;
      OP_SLT:        return ALU_SLT;
      default:       return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave):
// opcode/zero flag into the controller, state plus every enable and select out.
interface multicycle_control_unit_if;
  import multicycle_control_unit_pkg::*;

  logic [OP_W-1:0]    Opcode;
  logic               Zero;
  logic [2:0]         State;
  logic               PCWre;
  logic               InsMemRW;
  logic               IRWre;
  logic               ExtSel;
  logic               ALUSrcA;
  logic               ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               RegWre;
  logic [1:0]         RegDst;
  logic               WrRegDSrc;
  logic               DBDataSrc;
  logic               mRD;
  logic               mWR;
  logic [1:0]         PCSrc;

  modport master (
    input  Opcode, Zero,
    output State, PCWre, InsMemRW, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc
  );

  modport slave (
    output Opcode, Zero,
    input  State, PCWre, InsMemRW, IRWre, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc
  );

endinterface

// File: rtl/multicycle_control_unit_control_decode.sv
// Pure combinational map from FSM state, opcode and zero flag to the control vector.
// Controls are held across EXE/WB and MEMA/MEM/WBL so the unregistered selectors stay stable.
module multicycle_control_unit_control_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output ctrl_t           ctrl
);

  logic alu_imm;
  assign alu_imm = (opcode == OP_ADDI) || (opcode == OP_ORI);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.ins_mem_rw = 1'b1;
        ctrl.ir_wre     = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PC_JUMP;
          end
          OP_JR: begin
            ctrl.pc_wre = 1'b1;
            ctrl.pc_src = PC_REG;
          end
          OP_JAL: begin
            ctrl.pc_wre       = 1'b1;
            ctrl.pc_src       = PC_JUMP;
            ctrl.reg_wre      = 1'b1;
            ctrl.reg_dst      = RD_RA;
            ctrl.wr_reg_d_src = 1'b0;
          end
          default: begin
            // Illegal opcodes retire here as a no-op that advances PC.
            if (!is_legal(opcode)) begin
              ctrl.pc_wre = 1'b1;
              ctrl.pc_src = PC_NEXT;
            end
          end
        endcase
      end
      S_EXE, S_WB: begin
        ctrl.alu_op    = alu_op_of(opcode);
        ctrl.alu_src_a = (opcode == OP_SLL);
        ctrl.alu_src_b = alu_imm;
        ctrl.ext_sel   = (opcode == OP_ADDI);
        if (state == S_WB) begin
          ctrl.reg_wre      = 1'b1;
          ctrl.wr_reg_d_src = 1'b1;
          ctrl.db_data_src  = 1'b0;
          ctrl.reg_dst      = alu_imm ? RD_RT : RD_RD;
          ctrl.pc_wre       = 1'b1;
          ctrl.pc_src       = PC_NEXT;
        end
      end
      S_BEQ: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_src_b = 1'b0;
        ctrl.ext_sel   = 1'b1;
        ctrl.pc_wre    = 1'b1;
        ctrl.pc_src    = zero ? PC_BRANCH : PC_NEXT;
      end
      S_MEMA, S_MEM, S_WBL: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_b = 1'b1;
        ctrl.ext_sel   = 1'b1;
        if (state == S_MEM) begin
          if (opcode == OP_SW) begin
            ctrl.m_wr   = 1'b1;
            ctrl.pc_wre = 1'b1;
          end else if (opcode == OP_LW) begin
            ctrl.m_rd = 1'b1;
          end
        end
        if (state == S_WBL) begin
          ctrl.m_rd         = 1'b1;
          ctrl.db_data_src  = 1'b1;
          ctrl.reg_wre      = 1'b1;
          ctrl.reg_dst      = RD_RT;
          ctrl.wr_reg_d_src = 1'b1;
          ctrl.pc_wre       = 1'b1;
          ctrl.pc_src       = PC_NEXT;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM sequencing IF/ID/EXE/MEM/WB; only the state register is stored,
// all controls are decoded from it each cycle.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input logic                       CLK,
  input logic                       Reset,
  multicycle_control_unit_if.master bus
);

  state_t state;
  ctrl_t  ctrl;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          case (bus.Opcode)
            OP_J, OP_JR, OP_JAL: state <= S_IF;
            OP_HALT:             state <= S_ID;
            OP_BEQ:              state <= S_BEQ;
            OP_LW, OP_SW:        state <= S_MEMA;
            default:             state <= is_legal(bus.Opcode) ? S_EXE : S_IF;
          endcase
        end
        S_EXE:  state <= S_WB;
        S_WB:   state <= S_IF;
        S_BEQ:  state <= S_IF;
        S_MEMA: state <= S_MEM;
        S_MEM:  state <= (bus.Opcode == OP_LW) ? S_WBL : S_IF;
        S_WBL:  state <= S_IF;
        default: state <= S_IF;
      endcase
    end
  end

  multicycle_control_unit_control_decode u_decode (
    .state  (state),
    .opcode (bus.Opcode),
    .zero   (bus.Zero),
    .ctrl   (ctrl)
  );

  assign bus.State     = state;
  assign bus.InsMemRW  = ctrl.ins_mem_rw;
  assign bus.IRWre     = ctrl.ir_wre;
  assign bus.ExtSel    = ctrl.ext_sel;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.WrRegDSrc = ctrl.wr_reg_d_src;
  assign bus.DBDataSrc = ctrl.db_data_src;
  assign bus.mRD       = ctrl.m_rd;
  assign bus.PCSrc     = ctrl.pc_src;

  // Architectural writes are suppressed while Reset is sampled so an aborted instruction leaves no trace.
  assign bus.PCWre  = ctrl.pc_wre  & ~Reset;
  assign bus.RegWre = ctrl.reg_wre & ~Reset;
  assign bus.mWR    = ctrl.m_wr    & ~Reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each scenario queues the expected control vector for every cycle it
// drives, and the queue is drained against the DUT outputs sampled on the falling edge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       regwre;
    logic [1:0] regdst;
    logic       wrsrc;
    logic       dbsrc;
    logic       mrd;
    logic       mwr;
    logic       insmem;
    logic       irwre;
    logic [2:0] aluop;
    logic       srca;
    logic       srcb;
    logic       ext;
  } exp_t;

  logic CLK;
  logic Reset;
  int   vectors;
  int   miscompares;
  exp_t  exp_q[$];
  string name_q[$];

  multicycle_control_unit_if bus_if ();

  multicycle_control_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t rec(input logic [2:0] st);
    exp_t r;
    r = '0;
    r.st = st;
    if (st == 3'b000) begin
      r.insmem = 1'b1;
      r.irwre  = 1'b1;
    end
    return r;
  endfunction

  function automatic exp_t mem_rec(input logic [2:0] st);
    exp_t r;
    r = rec(st);
    r.aluop = 3'b000;
    r.srcb  = 1'b1;
    r.ext   = 1'b1;
    return r;
  endfunction

  function automatic exp_t capture();
    exp_t r;
    r.st     = bus_if.State;
    r.pcwre  = bus_if.PCWre;
    r.pcsrc  = bus_if.PCSrc;
    r.regwre = bus_if.RegWre;
    r.regdst = bus_if.RegDst;
    r.wrsrc  = bus_if.WrRegDSrc;
    r.dbsrc  = bus_if.DBDataSrc;
    r.mrd    = bus_if.mRD;
    r.mwr    = bus_if.mWR;
    r.insmem = bus_if.InsMemRW;
    r.irwre  = bus_if.IRWre;
    r.aluop  = bus_if.ALUOp;
    r.srca   = bus_if.ALUSrcA;
    r.srcb   = bus_if.ALUSrcB;
    r.ext    = bus_if.ExtSel;
    return r;
  endfunction

  task automatic push(input exp_t e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Pops one expectation per falling edge, then leaves the bench 1ns into the next cycle.
  task automatic drain(input int budget);
    exp_t  e;
    exp_t  act;
    string n;
    int    cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge CLK);
      act = capture();
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h (state got %b exp %b)", n, act, e, act.st, e.st);
      end
      cyc++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus_if.Opcode = 6'b000000;
    bus_if.Zero   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if (bus_if.State !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 000", bus_if.State);
    end
    vectors++;
    if ({bus_if.InsMemRW, bus_if.IRWre, bus_if.PCWre, bus_if.RegWre} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_if_outputs: got %b expected 1100",
               {bus_if.InsMemRW, bus_if.IRWre, bus_if.PCWre, bus_if.RegWre});
    end
    Reset = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [5:0] ops [8];
    logic [2:0] aluop [8];
    logic [3:0] sel [8];
    string      nm [8];
    exp_t e;
    ops   = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b011000, 6'b100111};
    aluop = '{3'b000,    3'b001,    3'b000,    3'b011,    3'b100,    3'b011,    3'b010,    3'b101};
    // {ALUSrcA, ALUSrcB, ExtSel, RegDst==rt}
    sel   = '{4'b0000,   4'b0000,   4'b0111,   4'b0000,   4'b0000,   4'b0101,   4'b1000,   4'b0000};
    nm    = '{"add",     "sub",     "addi",    "or",      "and",     "ori",     "sll",     "slt"};
    for (int i = 0; i < 8; i++) begin
      bus_if.Opcode = ops[i];
      bus_if.Zero   = 1'($urandom_range(0, 1));
      push(rec(3'b000), {nm[i], "_if"});
      push(rec(3'b001), {nm[i], "_id"});
      e = rec(3'b110);
      e.aluop = aluop[i];
      e.srca  = sel[i][3];
      e.srcb  = sel[i][2];
      e.ext   = sel[i][1];
      push(e, {nm[i], "_exe"});
      e.st     = 3'b111;
      e.regwre = 1'b1;
      e.wrsrc  = 1'b1;
      e.regdst = sel[i][0] ? 2'b01 : 2'b10;
      e.pcwre  = 1'b1;
      push(e, {nm[i], "_wb"});
      drain(8);
    end
  endtask

  task automatic test_lw();
    exp_t e;
    bus_if.Opcode = 6'b110001;
    bus_if.Zero   = 1'b1;
    push(rec(3'b000), "lw_if");
    push(rec(3'b001), "lw_id");
    push(mem_rec(3'b010), "lw_mema");
    e = mem_rec(3'b011);
    e.mrd = 1'b1;
    push(e, "lw_mem");
    e = mem_rec(3'b100);
    e.mrd    = 1'b1;
    e.dbsrc  = 1'b1;
    e.regwre = 1'b1;
    e.regdst = 2'b01;
    e.wrsrc  = 1'b1;
    e.pcwre  = 1'b1;
    push(e, "lw_wbl");
    drain(10);
  endtask

  task automatic test_sw();
    exp_t e;
    bus_if.Opcode = 6'b110000;
    bus_if.Zero   = 1'b0;
    push(rec(3'b000), "sw_if");
    push(rec(3'b001), "sw_id");
    push(mem_rec(3'b010), "sw_mema");
    e = mem_rec(3'b011);
    e.mwr   = 1'b1;
    e.pcwre = 1'b1;
    push(e, "sw_mem");
    drain(8);
  endtask

  task automatic test_beq();
    exp_t e;
    for (int z = 1; z >= 0; z--) begin
      bus_if.Opcode = 6'b110100;
      bus_if.Zero   = 1'(z);
      push(rec(3'b000), "beq_if");
      push(rec(3'b001), "beq_id");
      e = rec(3'b101);
      e.aluop = 3'b001;
      e.ext   = 1'b1;
      e.pcwre = 1'b1;
      e.pcsrc = (z == 1) ? 2'b01 : 2'b00;
      push(e, (z == 1) ? "beq_taken" : "beq_not_taken");
      drain(6);
    end
  endtask

  task automatic test_jumps();
    exp_t e;
    logic [5:0] ops [3];
    logic [1:0] src [3];
    ops = '{6'b111000, 6'b111001, 6'b111010};
    src = '{2'b11,     2'b10,     2'b11};
    for (int i = 0; i < 3; i++) begin
      bus_if.Opcode = ops[i];
      bus_if.Zero   = 1'($urandom_range(0, 1));
      push(rec(3'b000), "jump_if");
      e = rec(3'b001);
      e.pcwre = 1'b1;
      e.pcsrc = src[i];
      if (i == 2) e.regwre = 1'b1;
      push(e, (i == 0) ? "j_id" : (i == 1) ? "jr_id" : "jal_id");
      drain(4);
      vectors++;
      if (bus_if.State !== 3'b000) begin
        miscompares++;
        $display("FAIL jump_latency: got state %b expected 000", bus_if.State);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [5:0] ops [2];
    ops = '{6'b101010, 6'b000011};
    for (int i = 0; i < 2; i++) begin
      bus_if.Opcode = ops[i];
      push(rec(3'b000), "illegal_if");
      e = rec(3'b001);
      e.pcwre = 1'b1;
      push(e, "illegal_id");
      drain(4);
      vectors++;
      if (bus_if.State !== 3'b000) begin
        miscompares++;
        $display("FAIL illegal_return: got state %b expected 000", bus_if.State);
      end
    end
  endtask

  task automatic test_halt();
    bus_if.Opcode = 6'b111111;
    push(rec(3'b000), "halt_if");
    for (int i = 0; i < 10; i++) push(rec(3'b001), "halt_id");
    drain(14);
    vectors++;
    if (bus_if.State !== 3'b001 || bus_if.PCWre !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_hold: got state %b pcwre %b expected 001 0", bus_if.State, bus_if.PCWre);
    end
    Reset = 1'b1;
    push(rec(3'b001), "halt_reset_cycle");
    drain(3);
    vectors++;
    if (bus_if.State !== 3'b000) begin
      miscompares++;
      $display("FAIL halt_reset_exit: got state %b expected 000", bus_if.State);
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset_in_mem();
    exp_t e;
    bus_if.Opcode = 6'b110000;
    push(rec(3'b000), "swrst_if");
    push(rec(3'b001), "swrst_id");
    push(mem_rec(3'b010), "swrst_mema");
    drain(6);
    Reset = 1'b1;
    // sMEM of sw with Reset sampled: no memory or PC write may escape
    e = mem_rec(3'b011);
    push(e, "swrst_mem_blocked");
    drain(3);
    vectors++;
    if (bus_if.State !== 3'b000 || bus_if.mWR !== 1'b0) begin
      miscompares++;
      $display("FAIL swrst_after: got state %b mwr %b expected 000 0", bus_if.State, bus_if.mWR);
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    // lw directly followed by add: checks that return to sIF restarts cleanly
    test_lw();
    test_alu_ops();
    test_sw();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b1;
    test_reset();
    test_alu_ops();
    test_lw();
    test_sw();
    test_beq();
    test_jumps();
    test_illegal();
    test_halt();
    test_reset_in_mem();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style control FSM for the multicycle MIPS-subset CPU. It sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath enable and mux select. Its 2-bit selects (PCSrc, RegDst) feed the 4-input 32-bit selectors; its 1-bit selects feed the 2-input selectors. It has no datapath state of its own beyond the FSM register.

Parameters:
OP_W, 6, opcode width (instruction bits 31:26)
ALUOP_W, 3, ALU operation code width

Ports:
CLK  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high; forces State to sIF on the next CLK edge
Opcode  input  OP_W  opcode field from the instruction register (stable from ID onward)
Zero  input  1  ALU zero flag; sampled only in sBEQ
State  output  3  current FSM state (debug/visibility)
PCWre  output  1  PC write enable
InsMemRW  output  1  instruction memory read enable
IRWre  output  1  instruction register write enable
ExtSel  output  1  0 = zero-extend, 1 = sign-extend immediate
ALUSrcA  output  1  0 = rs, 1 = shamt
ALUSrcB  output  1  0 = rt, 1 = extended immediate
ALUOp  output  ALUOP_W  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
RegWre  output  1  register file write enable
RegDst  output  2  00 = $31, 01 = rt, 10 = rd, 11 unused (drive 00)
WrRegDSrc  output  1  0 = PC+4 (jal), 1 = DB bus
DBDataSrc  output  1  0 = ALU result, 1 = data memory
mRD  output  1  data memory read
mWR  output  1  data memory write
PCSrc  output  2  00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = jump target

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode is an illegal opcode.
- Only State is registered; all other outputs are a combinational function of State and Opcode (Zero in sBEQ only).
- Output defaults: every output not listed as asserted below is 0, including RegDst and PCSrc = 00.
- Reset: synchronous. State = sIF (000) after the edge, so IF outputs appear: InsMemRW = 1, IRWre = 1. Reset overrides any in-flight instruction; no PC or register write occurs in the cycle Reset is sampled.
- State encoding:
  - sIF = 000, sID = 001, sEXE = 110, sWB = 111
  - sBEQ = 101, sMEMA = 010, sMEM = 011, sWBL = 100
- Transitions:
  - sIF -> sID always.
  - sID -> sIF for j, jr, jal, and illegal opcodes.
  - sID -> sID for halt (self-loop until Reset).
  - sID -> sBEQ for beq; sID -> sMEMA for lw/sw; sID -> sEXE for all others.
  - sEXE -> sWB -> sIF.
  - sBEQ -> sIF.
  - sMEMA -> sMEM.
  - sMEM -> sIF for sw; sMEM -> sWBL for lw.
  - sWBL -> sIF.
- Latency: j/jr/jal 2 cycles; beq 3; R-type/immediate 4; sw 4; lw 5; halt infinite.
- PCWre = 1 only in the last cycle of an instruction:
  - sID for j/jr/jal and illegal opcodes; PCSrc = 11 for j/jal, 10 for jr, 00 for illegal.
  - sBEQ, with PCSrc = 01 if Zero else 00.
  - sMEM for sw, sWB, and sWBL, with PCSrc = 00.
- PCWre = 0 throughout halt.
- jal in sID: RegWre = 1, RegDst = 00, WrRegDSrc = 0.
- sEXE/sWB (ALU ops):
  - ALUOp per opcode.
  - ALUSrcB = 1 for addi/ori; ALUSrcA = 1 for sll.
  - ExtSel = 1 for addi, 0 for ori.
  - sWB only: RegWre = 1, WrRegDSrc = 1, DBDataSrc = 0; RegDst = 01 for addi/ori, 10 otherwise.
- sBEQ: ALUOp = 001, ALUSrcB = 0, ExtSel = 1.
- sMEMA/sMEM/sWBL: ALUOp = 000, ALUSrcB = 1, ExtSel = 1.
  - sMEM: mWR = 1 for sw, mRD = 1 for lw.
  - sWBL: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1.
- Holding controls across ALU/memory states keeps the unregistered selector outputs stable.
- RegWre and mWR are never both 1. PCWre is never 1 in sIF.

Decomposition:
- Shared package cpu_defs: opcode constants, state encodings, ALUOp codes, PCSrc/RegDst select codes (also used by the datapath selectors).
- One natural sub-module: control_decode, the pure combinational State+Opcode+Zero -> control vector. The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with Opcode = add -> State sequence 000,001,110,111,000; RegWre = 1 and RegDst = 10 only in 111; PCWre = 1 only in 111.
- lw (110001) -> states 000,001,010,011,100,000; mRD = 1 in 011 and 100; DBDataSrc = 1 and RegWre = 1 in 100; PCSrc = 00.
- beq with Zero = 1, then again with Zero = 0 -> both take 3 cycles; in 101, PCWre = 1 with PCSrc = 01, then 00.
- jal -> 2 cycles; in 001, PCWre = 1, PCSrc = 11, RegWre = 1, RegDst = 00, WrRegDSrc = 0. jr -> PCSrc = 10, RegWre = 0.
- halt (111111) for 10 cycles -> State stays 001 and PCWre = 0; Reset = 1 -> State = 000 next edge.
- Reset asserted in sMEM of sw -> State = 000 next edge with mWR = 0 in that cycle; illegal opcode 101010 -> 001 -> 000 with PCWre = 1, PCSrc = 00, RegWre = 0.
